vector_pe_pipe: RTL

Parametrised, pipelined successor to the fixed 8-lane vector processing element. Integer (two's-complement) operands, LANES lanes of DW bits, selectable per-beat mode: elementwise multiply, elementwise add, single-beat dot product, or multi-beat multiply-accumulate. Valid/ready on both sides, fixed latency, and a registered adder tree. Sits between the operand buffers and the result writeback in the vector ALU.

---
 rtl/vector_pe_pipe.sv | 301 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/vector_pe_pipe.sv
// vector_pe_pipe
// Pipelined vector processing element. Each beat carries LANES signed lanes
// of DW bits. The mode selects elementwise multiply, elementwise add,
// single-beat dot product, multi-beat multiply-accumulate, or a reserved
// code that returns an error beat.
//
// Pipeline (latency LG+2 from the accepting edge to out_valid):
//   input capture -> lane products/sums -> LG adder-tree levels -> accumulate/output
// A single global stall freezes every stage and the accumulator while a result
// is presented but not taken.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input handshake (in_ready low while rst or stalled)
//   mode[2:0]           000 MUL, 001 ADD, 010 DOT, 011 MAC, 1xx reserved
//   last                MAC only: closes the accumulation
//   a, b                LANES*DW packed operands, lane i at [i*DW +: DW]
//   out_valid/out_ready output handshake
//   out_vec             LANES*PW lane results (MUL/ADD)
//   out_scalar          ACCW-bit signed scalar (DOT/MAC)
//   out_err             result came from a reserved mode
//   out_ovf             accumulation saturated (only with VPE_SAT_EN)
//
// Configuration macro: VPE_SAT_EN
//   defined   -> MAC accumulator saturates, out_ovf flags the closing beat
//   undefined -> MAC accumulator wraps modulo 2^ACCW, out_ovf stays 0

module vector_pe_pipe #(
  parameter  int LANES     = 8,
  parameter  int DW        = 16,
  parameter  int ACC_GUARD = 8,
  localparam int PW        = 2 * DW,
  localparam int LG        = $clog2(LANES),
  localparam int ACCW      = PW + LG + ACC_GUARD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            mode,
  input  logic                  last,
  input  logic [LANES*DW-1:0]   a,
  input  logic [LANES*DW-1:0]   b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*PW-1:0]   out_vec,
  output logic [ACCW-1:0]       out_scalar,
  output logic                  out_err,
  output logic                  out_ovf
);

  // Tree storage width: full product width plus one bit per tree level.
  localparam int SW = PW + LG;

  typedef enum logic [2:0] {
    MODE_MUL = 3'b000,
    MODE_ADD = 3'b001,
    MODE_DOT = 3'b010,
    MODE_MAC = 3'b011
  } mode_e;

  logic stall;

  // Input capture stage
  logic                in_v_q, in_v_d;
  logic [2:0]          in_mode_q, in_mode_d;
  logic                in_last_q, in_last_d;
  logic [LANES*DW-1:0] in_a_q, in_a_d;
  logic [LANES*DW-1:0] in_b_q, in_b_d;

  // Stage 0 = lane products/sums, stages 1..LG = adder-tree levels
  logic                st_v_q    [LG+1];
  logic                st_v_d    [LG+1];
  logic [2:0]          st_mode_q [LG+1];
  logic [2:0]          st_mode_d [LG+1];
  logic                st_last_q [LG+1];
  logic                st_last_d [LG+1];
  logic [LANES*PW-1:0] st_vec_q  [LG+1];
  logic [LANES*PW-1:0] st_vec_d  [LG+1];
  logic signed [SW-1:0] st_tree_q [LG+1][LANES];
  logic signed [SW-1:0] st_tree_d [LG+1][LANES];

  // Lane arithmetic on the captured operands
  logic signed [DW-1:0] a_lane    [LANES];
  logic signed [DW-1:0] b_lane    [LANES];
  logic signed [PW-1:0] prod_lane [LANES];
  logic signed [PW-1:0] sum_lane  [LANES];

  // Output stage and accumulator
  logic                out_valid_q, out_valid_d;
  logic [LANES*PW-1:0] out_vec_q, out_vec_d;
  logic [ACCW-1:0]     out_scalar_q, out_scalar_d;
  logic                out_err_q, out_err_d;
  logic                out_ovf_q, out_ovf_d;
  logic [ACCW-1:0]     acc_q, acc_d;
  logic                sat_flag_q, sat_flag_d;

  logic signed [ACCW-1:0] dot_ext;
  logic [ACCW:0]          acc_sum_wide;
  logic [ACCW-1:0]        acc_sum;
  logic                   acc_sat;

  // A presented-but-untaken result freezes the whole pipe.
  assign stall    = out_valid_q && !out_ready;
  assign in_ready = !rst && !stall;

  // Capture a beat only on a real handshake; otherwise a bubble enters.
  always_comb begin
    in_v_d    = in_v_q;
    in_mode_d = in_mode_q;
    in_last_d = in_last_q;
    in_a_d    = in_a_q;
    in_b_d    = in_b_q;
    if (!stall) begin
      in_v_d = in_valid && in_ready;
      if (in_valid && in_ready) begin
        in_mode_d = mode;
        in_last_d = last;
        in_a_d    = a;
        in_b_d    = b;
      end
    end
  end

  // Exact signed lane products and sign-extended lane sums.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      a_lane[i]    = in_a_q[i*DW +: DW];
      b_lane[i]    = in_b_q[i*DW +: DW];
      prod_lane[i] = PW'(a_lane[i]) * PW'(b_lane[i]);
      sum_lane[i]  = PW'(a_lane[i]) + PW'(b_lane[i]);
    end
  end

  // Stage 0 registers the lane results; each tree level halves the number
  // of live partial sums. The lane vector rides along unchanged so MUL/ADD
  // results emerge with the same latency as the reductions.
  always_comb begin
    for (int s = 0; s <= LG; s++) begin
      st_v_d[s]    = st_v_q[s];
      st_mode_d[s] = st_mode_q[s];
      st_last_d[s] = st_last_q[s];
      st_vec_d[s]  = st_vec_q[s];
      for (int j = 0; j < LANES; j++) begin
        st_tree_d[s][j] = st_tree_q[s][j];
      end
    end
    if (!stall) begin
      st_v_d[0]    = in_v_q;
      st_mode_d[0] = in_mode_q;
      st_last_d[0] = in_last_q;
      st_vec_d[0]  = '0;
      for (int i = 0; i < LANES; i++) begin
        st_tree_d[0][i] = SW'(prod_lane[i]);
        if (in_mode_q == MODE_MUL) begin
          st_vec_d[0][i*PW +: PW] = prod_lane[i];
        end else if (in_mode_q == MODE_ADD) begin
          st_vec_d[0][i*PW +: PW] = sum_lane[i];
        end
      end
      for (int s = 1; s <= LG; s++) begin
        st_v_d[s]    = st_v_q[s-1];
        st_mode_d[s] = st_mode_q[s-1];
        st_last_d[s] = st_last_q[s-1];
        st_vec_d[s]  = st_vec_q[s-1];
        for (int j = 0; j < LANES; j++) begin
          st_tree_d[s][j] = '0;
        end
        for (int j = 0; j < LANES / 2; j++) begin
          if (j < (LANES >> s)) begin
            st_tree_d[s][j] = st_tree_q[s-1][2*j] + st_tree_q[s-1][2*j+1];
          end
        end
      end
    end
  end

  // Accumulator adder, one bit wider so overflow is visible as a mismatch
  // between the top two bits.
  assign dot_ext = ACCW'(st_tree_q[LG][0]);

  always_comb begin
    acc_sum_wide = {acc_q[ACCW-1], acc_q} + {dot_ext[ACCW-1], dot_ext};
`ifdef VPE_SAT_EN
    if (acc_sum_wide[ACCW] != acc_sum_wide[ACCW-1]) begin
      acc_sat = 1'b1;
      acc_sum = acc_sum_wide[ACCW] ? {1'b1, {(ACCW-1){1'b0}}}
                                   : {1'b0, {(ACCW-1){1'b1}}};
    end else begin
      acc_sat = 1'b0;
      acc_sum = acc_sum_wide[ACCW-1:0];
    end
`else
    acc_sat = 1'b0;
    acc_sum = acc_sum_wide[ACCW-1:0];
`endif
  end

  // Output stage: outputs are cleared on every non-result cycle, MAC beats
  // without last are absorbed into acc and produce a bubble, and only MAC
  // touches acc or the saturation flag.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_vec_d    = out_vec_q;
    out_scalar_d = out_scalar_q;
    out_err_d    = out_err_q;
    out_ovf_d    = out_ovf_q;
    acc_d        = acc_q;
    sat_flag_d   = sat_flag_q;
    if (!stall) begin
      out_valid_d  = 1'b0;
      out_vec_d    = '0;
      out_scalar_d = '0;
      out_err_d    = 1'b0;
      out_ovf_d    = 1'b0;
      if (st_v_q[LG]) begin
        case (st_mode_q[LG])
          MODE_MUL, MODE_ADD: begin
            out_valid_d = 1'b1;
            out_vec_d   = st_vec_q[LG];
          end
          MODE_DOT: begin
            out_valid_d  = 1'b1;
            out_scalar_d = dot_ext;
          end
          MODE_MAC: begin
            if (st_last_q[LG]) begin
              out_valid_d  = 1'b1;
              out_scalar_d = acc_sum;
              out_ovf_d    = sat_flag_q || acc_sat;
              acc_d        = '0;
              sat_flag_d   = 1'b0;
            end else begin
              acc_d      = acc_sum;
              sat_flag_d = sat_flag_q || acc_sat;
            end
          end
          default: begin
            out_valid_d = 1'b1;
            out_err_d   = 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_v_q    <= 1'b0;
      in_mode_q <= '0;
      in_last_q <= 1'b0;
      in_a_q    <= '0;
      in_b_q    <= '0;
      for (int s = 0; s <= LG; s++) begin
        st_v_q[s]    <= 1'b0;
        st_mode_q[s] <= '0;
        st_last_q[s] <= 1'b0;
        st_vec_q[s]  <= '0;
        for (int j = 0; j < LANES; j++) begin
          st_tree_q[s][j] <= '0;
        end
      end
      out_valid_q  <= 1'b0;
      out_vec_q    <= '0;
      out_scalar_q <= '0;
      out_err_q    <= 1'b0;
      out_ovf_q    <= 1'b0;
      acc_q        <= '0;
      sat_flag_q   <= 1'b0;
    end else begin
      in_v_q    <= in_v_d;
      in_mode_q <= in_mode_d;
      in_last_q <= in_last_d;
      in_a_q    <= in_a_d;
      in_b_q    <= in_b_d;
      for (int s = 0; s <= LG; s++) begin
        st_v_q[s]    <= st_v_d[s];
        st_mode_q[s] <= st_mode_d[s];
        st_last_q[s] <= st_last_d[s];
        st_vec_q[s]  <= st_vec_d[s];
        for (int j = 0; j < LANES; j++) begin
          st_tree_q[s][j] <= st_tree_d[s][j];
        end
      end
      out_valid_q  <= out_valid_d;
      out_vec_q    <= out_vec_d;
      out_scalar_q <= out_scalar_d;
      out_err_q    <= out_err_d;
      out_ovf_q    <= out_ovf_d;
      acc_q        <= acc_d;
      sat_flag_q   <= sat_flag_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_vec    = out_vec_q;
  assign out_scalar = out_scalar_q;
  assign out_err    = out_err_q;
  assign out_ovf    = out_ovf_q;

endmodule
